// File: rtl/serial_pair_msb_serializer.sv
// Parallel-to-serial front end for an MSB-first serial comparator: accepts operand
// pairs over valid/ready and streams them one bit pair per cycle, each word led by cmp_clear.
module serial_pair_msb_serializer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         cmp_clear,
  output logic         ser_valid,
  output logic         ser_a,
  output logic         ser_b,
  output logic         ser_first,
  output logic         ser_last
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sh_a_q, sh_a_d;
  logic [W-1:0]  sh_b_q, sh_b_d;
  logic [W-1:0]  pend_a_q, pend_a_d;
  logic [W-1:0]  pend_b_q, pend_b_d;
  logic          pend_full_q, pend_full_d;

  logic xfer;
  logic load_slot;

  // Ready depends only on the pending flag, never on in_valid.
  assign xfer      = in_valid & ~pend_full_q;
  assign load_slot = (state_q == S_IDLE) || ((state_q == S_SHIFT) && (cnt_q == '0));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    pend_a_d    = pend_a_q;
    pend_b_d    = pend_b_q;
    pend_full_d = pend_full_q;

    case (state_q)
      S_CLEAR: begin
        state_d = S_SHIFT;
        cnt_d   = LAST_CNT;
      end
      S_SHIFT: begin
        sh_a_d = sh_a_q << 1;
        sh_b_d = sh_b_q << 1;
        cnt_d  = cnt_q - CW'(1);
      end
      default: ;
    endcase

    // The pending word always has priority over a fresh transfer at a word boundary.
    if (load_slot) begin
      cnt_d = '0;
      if (pend_full_q) begin
        sh_a_d      = pend_a_q;
        sh_b_d      = pend_b_q;
        pend_full_d = 1'b0;
        state_d     = S_CLEAR;
      end else if (xfer) begin
        sh_a_d  = in_a;
        sh_b_d  = in_b;
        state_d = S_CLEAR;
      end else begin
        state_d = S_IDLE;
      end
    end else if (xfer) begin
      pend_a_d    = in_a;
      pend_b_d    = in_b;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      pend_a_q    <= '0;
      pend_b_q    <= '0;
      pend_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      pend_a_q    <= pend_a_d;
      pend_b_q    <= pend_b_d;
      pend_full_q <= pend_full_d;
    end
  end

  assign in_ready  = ~pend_full_q;
  assign cmp_clear = (state_q == S_CLEAR);
  assign ser_valid = (state_q == S_SHIFT);
  assign ser_a     = ser_valid & sh_a_q[W-1];
  assign ser_b     = ser_valid & sh_b_q[W-1];
  assign ser_first = ser_valid & (cnt_q == LAST_CNT);
  assign ser_last  = ser_valid & (cnt_q == '0);

endmodule

// File: tb/tb_serial_pair_msb_serializer.sv
// Directed vector tables, reset/W=1 sequences and a randomized scoreboard run
// for serial_pair_msb_serializer, with a bench-side MSB-first comparator model.
module tb_serial_pair_msb_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // W=8 instance
  logic       in_valid, in_ready, cmp_clear, ser_valid, ser_a, ser_b, ser_first, ser_last;
  logic [7:0] in_a, in_b;
  // W=1 instance
  logic       v1, r1, c1, sv1, sa1, sb1, f1, l1;
  logic [0:0] a1, b1;

  serial_pair_msb_serializer #(.W(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .cmp_clear(cmp_clear), .ser_valid(ser_valid),
    .ser_a(ser_a), .ser_b(ser_b), .ser_first(ser_first), .ser_last(ser_last)
  );

  serial_pair_msb_serializer #(.W(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1),
    .in_a(a1), .in_b(b1), .cmp_clear(c1), .ser_valid(sv1),
    .ser_a(sa1), .ser_b(sb1), .ser_first(f1), .ser_last(l1)
  );

  // {in_ready, cmp_clear, ser_valid, ser_a, ser_b, ser_first, ser_last}
  logic [6:0] o8, o1;
  assign o8 = {in_ready, cmp_clear, ser_valid, ser_a, ser_b, ser_first, ser_last};
  assign o1 = {r1, c1, sv1, sa1, sb1, f1, l1};

  localparam logic [6:0] IDLE_O  = 7'b1000000;
  localparam logic [6:0] CLR_R1  = 7'b1100000;

  typedef struct {
    logic       v;
    logic [7:0] a;
    logic [7:0] b;
    logic [6:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] exp_q[$];
  logic [1:0]  res_q[$];
  logic [1:0]  cmp_st;
  logic [7:0]  ra, rb;
  bit          sb_en;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Downstream comparator model plus word scoreboard, sampled mid-cycle.
  task automatic monitor();
    logic [15:0] e;
    logic [1:0]  er;
    if (cmp_clear) cmp_st = 2'd0;
    if (ser_valid) begin
      if (ser_first) begin
        ra = '0;
        rb = '0;
      end
      ra = {ra[6:0], ser_a};
      rb = {rb[6:0], ser_b};
      if (cmp_st == 2'd0 && ser_a != ser_b) cmp_st = ser_a ? 2'd1 : 2'd2;
      if (ser_last) begin
        res_q.push_back(cmp_st);
        if (sb_en) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_word", {ra, rb}, 16'hxxxx);
          end else begin
            e  = exp_q.pop_front();
            er = (e[15:8] == e[7:0]) ? 2'd0 : (e[15:8] > e[7:0]) ? 2'd1 : 2'd2;
            chk("sb_word", {ra, rb}, e);
            chk("sb_cmp", {14'd0, cmp_st}, {14'd0, er});
          end
        end
      end
    end
    if (sb_en && in_valid && in_ready) exp_q.push_back({in_a, in_b});
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [6:0] e);
    vec_t t;
    t.v = v; t.a = a; t.b = b; t.exp = e;
    tbl.push_back(t);
  endtask

  task automatic push_word(input logic [7:0] a, input logic [7:0] b, input logic rdy,
                           input logic v, input logic [7:0] na, input logic [7:0] nb);
    for (int k = 7; k >= 0; k--)
      push(v, na, nb, {rdy, 1'b0, 1'b1, a[k], b[k], (k == 7), (k == 0)});
  endtask

  task automatic run_table(input bit w1);
    vec_t t;
    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      chk($sformatf("%s_vec%0d", w1 ? "w1" : "w8", i),
          {9'd0, (w1 ? o1 : o8)}, {9'd0, t.exp});
      if (w1) begin
        v1 = t.v; a1 = t.a[0]; b1 = t.b[0];
      end else begin
        in_valid = t.v; in_a = t.a; in_b = t.b;
      end
      tick();
    end
    in_valid = 1'b0; v1 = 1'b0;
    tbl.delete();
  endtask

  initial begin
    int acc;
    int cyc;
    logic [1:0] exp_res[5];

    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0;
    v1 = 1'b0; a1 = '0; b1 = '0;
    cmp_st = 2'd0; ra = '0; rb = '0; sb_en = 1'b1;
    #3;
    chk("reset_w8", {9'd0, o8}, {9'd0, IDLE_O});
    chk("reset_w1", {9'd0, o1}, {9'd0, IDLE_O});
    #9 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single word, idle gap, second word, then three back-to-back pairs.
    push(1'b1, 8'hA5, 8'hA6, IDLE_O);
    push(1'b0, 8'h00, 8'h00, CLR_R1);
    push_word(8'hA5, 8'hA6, 1'b1, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) push(1'b0, 8'h00, 8'h00, IDLE_O);
    push(1'b1, 8'h3C, 8'h0F, IDLE_O);
    push(1'b0, 8'h00, 8'h00, CLR_R1);
    push_word(8'h3C, 8'h0F, 1'b1, 1'b0, 8'h00, 8'h00);
    push(1'b0, 8'h00, 8'h00, IDLE_O);
    push(1'b1, 8'h12, 8'h12, IDLE_O);
    push(1'b1, 8'hFF, 8'h00, CLR_R1);
    push_word(8'h12, 8'h12, 1'b0, 1'b1, 8'h00, 8'h80);
    push(1'b1, 8'h00, 8'h80, CLR_R1);
    push_word(8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    push(1'b0, 8'h00, 8'h00, CLR_R1);
    push_word(8'h00, 8'h80, 1'b1, 1'b0, 8'h00, 8'h00);
    push(1'b0, 8'h00, 8'h00, IDLE_O);
    push(1'b0, 8'h00, 8'h00, IDLE_O);
    res_q.delete();
    run_table(1'b0);

    exp_res = '{2'd2, 2'd1, 2'd0, 2'd1, 2'd2};
    chk("cmp_result_count", 16'(res_q.size()), 16'd5);
    for (int i = 0; i < 5 && i < res_q.size(); i++)
      chk($sformatf("cmp_result%0d", i), {14'd0, res_q[i]}, {14'd0, exp_res[i]});

    // Asynchronous reset during the 4th bit with a pending word held.
    sb_en = 1'b0;
    in_valid = 1'b1; in_a = 8'h3C; in_b = 8'hC3;
    tick();
    in_a = 8'h5A; in_b = 8'hA5;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("pre_reset_4th_bit", {9'd0, o8}, {9'd0, 7'b0011000});
    #2 rst = 1'b1;
    #1;
    chk("async_reset_now", {9'd0, o8}, {9'd0, IDLE_O});
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("post_reset_quiet%0d", i), {9'd0, o8}, {9'd0, IDLE_O});
      tick();
    end
    exp_q.delete();
    sb_en = 1'b1;

    // W=1: two words back-to-back, period 2.
    push(1'b1, 8'h01, 8'h00, IDLE_O);
    push(1'b1, 8'h00, 8'h01, CLR_R1);
    push(1'b0, 8'h00, 8'h00, 7'b0011011);
    push(1'b0, 8'h00, 8'h00, CLR_R1);
    push(1'b0, 8'h00, 8'h00, 7'b1010111);
    push(1'b0, 8'h00, 8'h00, IDLE_O);
    run_table(1'b1);

    // Randomized traffic checked by the scoreboard in monitor().
    acc = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 30000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      if (in_valid && in_ready) acc++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("random_accepted", 16'(acc), 16'd1000);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("random_drained", 16'(exp_q.size()), 16'd0);
    tick();
    chk("final_idle", {9'd0, o8}, {9'd0, IDLE_O});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
